// File: rtl/capture_ctrl_if.sv
// rtl/capture_ctrl_if.sv - capture controller control/status bundle with host and controller views
interface capture_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int TO_W   = 16
);
  logic              start;
  logic [ADDR_W-1:0] trig_pos;
  logic              smpl_en;
  logic              trigger;
  logic              capture_ack;
  logic [TO_W-1:0]   to_limit;
  logic              armed;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] trig_addr;
  logic              set_capture_done;
  logic              capture_done;
  logic              busy;
  logic              auto_trig;

  // Host / decimator / trigger-unit side
  modport master (
    output start, trig_pos, smpl_en, trigger, capture_ack, to_limit,
    input  armed, we, waddr, trig_addr, set_capture_done, capture_done, busy, auto_trig
  );

  // Capture controller side
  modport slave (
    input  start, trig_pos, smpl_en, trigger, capture_ack, to_limit,
    output armed, we, waddr, trig_addr, set_capture_done, capture_done, busy, auto_trig
  );
endinterface

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - scope acquisition sequencer (pre-fill, arm, post-trigger, done); optional CAPTURE_AUTOTRIG_EN timeout
module capture_ctrl #(
  parameter int ADDR_W = 9,
  parameter int TO_W   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  capture_ctrl_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   CNT_ONE   = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] tp_q, tp_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   pre_cnt;
  logic              we;
  logic              set_done;
  logic              to_hit;

  // Pre-trigger sample count; one bit wider so tp==0 yields a full-depth fill
  assign pre_cnt = DEPTH_CNT - {1'b0, tp_q};

`ifdef CAPTURE_AUTOTRIG_EN
  localparam logic [TO_W-1:0] TO_ONE = 1;

  logic [TO_W-1:0] to_q, to_d;
  logic            auto_q, auto_d;

  // Timeout counter only runs in ARMED, so it is zero on every entry to ARMED
  always_comb begin
    to_d   = '0;
    to_hit = 1'b0;
    if (state_q == ARMED) begin
      to_d   = bus.smpl_en ? (to_q + TO_ONE) : to_q;
      to_hit = bus.smpl_en && (bus.to_limit != '0) && ((to_q + TO_ONE) == bus.to_limit);
    end
  end

  // Timeout counter and auto-trigger flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q   <= '0;
      auto_q <= 1'b0;
    end else begin
      to_q   <= to_d;
      auto_q <= auto_d;
    end
  end

  assign bus.auto_trig = auto_q;
`else
  assign to_hit        = 1'b0;
  assign bus.auto_trig = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      waddr_q     <= '0;
      trig_addr_q <= '0;
      tp_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      trig_addr_q <= trig_addr_d;
      tp_q        <= tp_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state, write enable and done pulse
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    trig_addr_d = trig_addr_q;
    tp_d        = tp_q;
    cnt_d       = cnt_q;
    we          = 1'b0;
    set_done    = 1'b0;
`ifdef CAPTURE_AUTOTRIG_EN
    auto_d      = auto_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FILL;
          waddr_d = '0;
          cnt_d   = '0;
          tp_d    = bus.trig_pos;
`ifdef CAPTURE_AUTOTRIG_EN
          auto_d  = 1'b0;
`endif
        end
      end
      FILL: begin
        we = bus.smpl_en;
        if (bus.smpl_en) begin
          cnt_d = cnt_q + CNT_ONE;
          // Leave on the cycle after the last pre-trigger write
          if ((cnt_q + CNT_ONE) == pre_cnt) begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        we = bus.smpl_en;
        if (bus.trigger || to_hit) begin
          state_d = POST;
          cnt_d   = '0;
          // A coincident sample belongs to the pre-trigger history,
          // so the first post sample lands one address later
          trig_addr_d = bus.smpl_en ? (waddr_q + ADDR_ONE) : waddr_q;
`ifdef CAPTURE_AUTOTRIG_EN
          auto_d = !bus.trigger;
`endif
        end
      end
      POST: begin
        // Checked before writing so tp==0 exits at once with no post writes
        if (cnt_q == {1'b0, tp_q}) begin
          state_d  = DONE;
          set_done = 1'b1;
        end else begin
          we = bus.smpl_en;
          if (bus.smpl_en) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      DONE: begin
        if (bus.capture_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (we) begin
      waddr_d = waddr_q + ADDR_ONE;
    end
  end

  assign bus.armed            = (state_q == ARMED);
  assign bus.busy             = (state_q == FILL) || (state_q == ARMED) || (state_q == POST);
  assign bus.capture_done     = (state_q == DONE);
  assign bus.set_capture_done = set_done;
  assign bus.we               = we;
  assign bus.waddr            = waddr_q;
  assign bus.trig_addr        = trig_addr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb/tb_capture_ctrl.sv - scoreboard bench for capture_ctrl (ADDR_W=4)
module tb_capture_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  capture_ctrl_if #(.ADDR_W(4), .TO_W(16)) bus ();

  capture_ctrl #(.ADDR_W(4), .TO_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int wr_count = 0;
  int done_cnt = 0;

  logic [3:0] wq[$];
  logic [3:0] dq_addr[$];
  logic       dq_auto[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every RAM write and done pulse is matched against the queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.we) begin
        wr_count++;
        if (wq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL wr_unexpected: got write at %0d, want no write", bus.waddr);
        end else begin
          chk("wr_addr", int'(bus.waddr), int'(wq.pop_front()));
        end
      end
      if (bus.set_capture_done) begin
        done_cnt++;
        if (dq_addr.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done_unexpected: got set_capture_done=1, want 0");
        end else begin
          chk("done_trig_addr", int'(bus.trig_addr), int'(dq_addr.pop_front()));
          chk("done_auto_trig", int'(bus.auto_trig), int'(dq_auto.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_armed"},     int'(bus.armed), 0);
    chk({tag, "_we"},        int'(bus.we), 0);
    chk({tag, "_waddr"},     int'(bus.waddr), 0);
    chk({tag, "_trig_addr"}, int'(bus.trig_addr), 0);
    chk({tag, "_set_done"},  int'(bus.set_capture_done), 0);
    chk({tag, "_done"},      int'(bus.capture_done), 0);
    chk({tag, "_busy"},      int'(bus.busy), 0);
    chk({tag, "_auto"},      int'(bus.auto_trig), 0);
  endtask

  task automatic wait_armed(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.armed) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_armed_timeout"}, int'(seen), 1);
  endtask

  task automatic wait_done_pulse(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.set_capture_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_timeout"}, int'(seen), 1);
  endtask

  task automatic ack_done(input string tag);
    bus.capture_ack = 1'b1;
    tick();
    bus.capture_ack = 1'b0;
    chk({tag, "_ack_done"}, int'(bus.capture_done), 0);
    chk({tag, "_ack_busy"}, int'(bus.busy), 0);
  endtask

  // tp=4, smpl_en held: 12 fill writes, trigger at waddr=14 with no sample, 4 post writes
  task automatic run_basic(input string tag);
    int base;
    for (int i = 0; i < 18; i++) wq.push_back(4'(i));
    dq_addr.push_back(4'd14);
    dq_auto.push_back(1'b0);
    base = wr_count;
    bus.trig_pos = 4'd4;
    bus.smpl_en  = 1'b0;
    bus.start    = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.smpl_en = 1'b1;
    wait_armed(tag);
    chk({tag, "_fill_writes"}, wr_count - base, 12);
    chk({tag, "_armed_waddr"}, int'(bus.waddr), 12);
    tick();
    tick();
    bus.smpl_en = 1'b0;
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    bus.smpl_en = 1'b1;
    chk({tag, "_trig_addr"}, int'(bus.trig_addr), 14);
    wait_done_pulse(tag);
    chk({tag, "_pulse_we"}, int'(bus.we), 0);
    tick();
    chk({tag, "_done_level"}, int'(bus.capture_done), 1);
    chk({tag, "_done_we"}, int'(bus.we), 0);
    chk({tag, "_done_pulse_gone"}, int'(bus.set_capture_done), 0);
    chk({tag, "_done_busy"}, int'(bus.busy), 0);
    bus.smpl_en = 1'b0;
    chk({tag, "_total_writes"}, wr_count - base, 18);
    ack_done(tag);
  endtask

  initial begin
    int base;
    int sidx;
    bit got;
    bit start_done;
    bit ack_done_f;

    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.trig_pos    = '0;
    bus.smpl_en     = 1'b0;
    bus.trigger     = 1'b0;
    bus.capture_ack = 1'b0;
    bus.to_limit    = '0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Capture_ack and trigger in IDLE do nothing
    bus.capture_ack = 1'b1;
    bus.trigger     = 1'b1;
    tick();
    bus.capture_ack = 1'b0;
    bus.trigger     = 1'b0;
    chk("idle_ack_busy", int'(bus.busy), 0);
    chk("idle_ack_done", int'(bus.capture_done), 0);

    run_basic("basic");

    // tp=0: 16 fill writes, one ARMED write, coincident trigger at waddr=1, no post writes
    for (int i = 0; i < 18; i++) wq.push_back(4'(i));
    dq_addr.push_back(4'd2);
    dq_auto.push_back(1'b0);
    base = wr_count;
    bus.trig_pos = 4'd0;
    bus.start    = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.smpl_en = 1'b1;
    wait_armed("tp0");
    chk("tp0_fill_writes", wr_count - base, 16);
    chk("tp0_armed_waddr", int'(bus.waddr), 0);
    tick();
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    chk("tp0_pulse", int'(bus.set_capture_done), 1);
    chk("tp0_pulse_we", int'(bus.we), 0);
    chk("tp0_trig_addr", int'(bus.trig_addr), 2);
    tick();
    chk("tp0_pulse_gone", int'(bus.set_capture_done), 0);
    chk("tp0_done_level", int'(bus.capture_done), 1);
    bus.smpl_en = 1'b0;
    chk("tp0_total_writes", wr_count - base, 18);
    ack_done("tp0");

    // tp=12, sample every 3rd cycle, trigger with the write at waddr=5; stray start and ack
    for (int i = 0; i < 18; i++) wq.push_back(4'(i));
    dq_addr.push_back(4'd6);
    dq_auto.push_back(1'b0);
    base = wr_count;
    bus.trig_pos = 4'd12;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.trig_pos = 4'd3;
    sidx = 0;
    got = 1'b0;
    start_done = 1'b0;
    ack_done_f = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      bit p_start;
      bit p_ack;
      bus.smpl_en     = ((cyc % 3) == 2);
      bus.trigger     = bus.smpl_en && (sidx == 5);
      p_start         = !bus.smpl_en && (sidx == 4) && !start_done;
      p_ack           = !bus.smpl_en && (sidx == 8) && !ack_done_f;
      bus.start       = p_start;
      bus.capture_ack = p_ack;
      if (p_start) start_done = 1'b1;
      if (p_ack) ack_done_f = 1'b1;
      tick();
      if (bus.smpl_en) sidx++;
      bus.start       = 1'b0;
      bus.capture_ack = 1'b0;
      bus.trigger     = 1'b0;
      if (p_start) begin
        chk("stray_start_armed", int'(bus.armed), 1);
        chk("stray_start_waddr", int'(bus.waddr), 4);
      end
      if (p_ack) begin
        chk("stray_ack_busy", int'(bus.busy), 1);
        chk("stray_ack_done", int'(bus.capture_done), 0);
      end
      if (bus.set_capture_done) begin
        got = 1'b1;
        break;
      end
    end
    chk("sparse_done_timeout", int'(got), 1);
    bus.smpl_en = 1'b0;
    chk("sparse_trig_addr", int'(bus.trig_addr), 6);
    chk("sparse_total_writes", wr_count - base, 18);
    tick();
    chk("sparse_done_level", int'(bus.capture_done), 1);
    ack_done("sparse");

    // tp=8 with trigger held from start: ignored in FILL, taken on first ARMED cycle; reset mid-POST
    for (int i = 0; i < 11; i++) wq.push_back(4'(i));
    base = wr_count;
    bus.trig_pos = 4'd8;
    bus.trigger  = 1'b1;
    bus.start    = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.smpl_en = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    chk("post_busy", int'(bus.busy), 1);
    chk("post_armed", int'(bus.armed), 0);
    chk("post_trig_addr", int'(bus.trig_addr), 9);
    chk("post_writes", wr_count - base, 11);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    bus.trigger = 1'b0;
    bus.smpl_en = 1'b0;
    tick();
    tick();
    chk("rst_no_done", done_cnt, 3);
    rst_n = 1'b1;
    tick();

    run_basic("after_rst");

`ifdef CAPTURE_AUTOTRIG_EN
    // Auto-trigger: 12 fill, 10 ARMED samples (last at waddr=5), 4 post writes
    for (int i = 0; i < 26; i++) wq.push_back(4'(i));
    dq_addr.push_back(4'd6);
    dq_auto.push_back(1'b1);
    base = wr_count;
    bus.to_limit = 16'd10;
    bus.trig_pos = 4'd4;
    bus.start    = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.smpl_en = 1'b1;
    wait_done_pulse("auto");
    chk("auto_trig_flag", int'(bus.auto_trig), 1);
    chk("auto_total_writes", wr_count - base, 26);
    tick();
    bus.smpl_en = 1'b0;
    chk("auto_done_level", int'(bus.capture_done), 1);
    ack_done("auto");
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("auto_cleared", int'(bus.auto_trig), 0);
`endif

    tick();
    chk("wq_empty", wq.size(), 0);
    chk("dq_empty", dq_addr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
